std_seq_ctrl: RTL and testbench
===============================

Name: std_seq_ctrl

Overview:
Sequencing controller for the 3-bit state-transition-diagram code generator. It steps through the fixed 8-code cycle 0,4,1,3,6,2,7,5 under command control. Supported commands: clear, run continuously, run N steps, single step. Step rate is set by a programmable prescaler; hold and abort controls are provided. It sits between the control/register logic and the display/decode logic that consumes the code.

Parameters:
DIV_W, 8, prescaler width; step period = cfg_div+1 clock cycles
CNT_W, 8, width of the step-count field for RUN_CNT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_div  input  DIV_W  step period minus one; sampled on command acceptance
cmd_valid  input  1  command request
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 CLEAR, 01 RUN_CONT, 10 RUN_CNT, 11 STEP
cmd_cnt  input  CNT_W  number of steps for RUN_CNT; sampled on acceptance
hold  input  1  freezes prescaler while high
abort  input  1  synchronous stop of any running command
seq_out  output  3  current code from the sequence table
seq_idx  output  3  current position 0..7 in the sequence
busy  output  1  high in RUN_CONT/RUN_CNT
step_pulse  output  1  one-cycle pulse coincident with each new seq_out value
wrap_pulse  output  1  one-cycle pulse with the step that moves idx 7->0
done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (rst low, async): state IDLE, seq_idx=0, seq_out=0, prescaler=0, busy=0, step_pulse=0, wrap_pulse=0, done=0, cmd_ready=1. Commands have no effect while rst is low.
- Sequence table by index 0..7: 0,4,1,3,6,2,7,5. seq_out is the table entry for the registered seq_idx. Index increments modulo 8.
- States: IDLE, RUN_CONT, RUN_CNT, CLR_ACK. cmd_ready = (state==IDLE).
- Acceptance: at a rising edge with cmd_valid & cmd_ready. At that edge cfg_div is latched into div_r and the prescaler is cleared.
  - CLEAR: seq_idx <- 0; go to CLR_ACK. done=1 for that one cycle, then IDLE.
  - RUN_CONT: go to RUN_CONT.
  - RUN_CNT with cmd_cnt=0: no step; go to CLR_ACK. done pulses next cycle; seq_idx unchanged.
  - RUN_CNT with cmd_cnt=N>0: remaining <- N; go to RUN_CNT.
  - STEP: identical to RUN_CNT with N=1; cmd_cnt is ignored.
- Prescaler, in run states only:
  - hold=0 and prescaler<div_r: increment.
  - hold=0 and prescaler==div_r: step edge; prescaler <- 0.
  - hold=1: prescaler frozen, no step.
- Step edge:
  - seq_idx advances.
  - step_pulse=1 in the cycle after the edge, aligned with the new seq_out.
  - wrap_pulse=1 as well if seq_idx became 0.
- Timing: the first step edge is div_r+1 cycles after the acceptance edge. Later steps follow every div_r+1 cycles, extended by any cycles with hold=1. With cfg_div=0, a step occurs on every edge.
- RUN_CNT: remaining decrements on each step edge. On the step edge where remaining==1:
  - state <- IDLE;
  - done=1 in the same cycle as that final step_pulse;
  - busy falls in that cycle.
- RUN_CONT runs until abort.
- abort in a run state:
  - next edge: state <- IDLE, prescaler <- 0; seq_idx kept;
  - no done pulse;
  - if the same edge was a step edge, abort wins and no step occurs.
- abort in IDLE/CLR_ACK: ignored.
- seq_idx persists across commands. Only CLEAR and reset return it to 0.
- Reset asserted mid-run: immediate return to reset values; the run is not resumed.
- cfg_div/cmd_cnt changes after acceptance have no effect on the running command.

Test Plan:
- Reset, then CLEAR -> seq_out=0, done one cycle after acceptance. Then RUN_CNT cfg_div=0 cmd_cnt=8 -> seq_out 4,1,3,6,2,7,5,0 on 8 consecutive cycles; wrap_pulse and done with the last step; busy low afterward.
- RUN_CONT cfg_div=3 -> step_pulse every 4 cycles, first 4 cycles after acceptance. Assert hold for 5 cycles mid-period -> next step delayed by exactly 5 cycles.
- STEP with cmd_cnt=200 from idx 2 -> exactly one step, seq_out 1->3, done coincident with step_pulse, cmd_ready high next cycle.
- RUN_CNT cmd_cnt=0 -> no step_pulse, done one cycle after acceptance, seq_idx unchanged.
- RUN_CONT cfg_div=0, abort asserted on a step edge -> no step on that edge, state IDLE, no done, seq_idx kept. Command held valid during the run is not accepted until cmd_ready=1.
- rst low mid RUN_CNT at idx 5 -> outputs 0 immediately (async), cmd_ready=1 after release, no residual step or done.

Source files
------------

// File: rtl/std_seq_ctrl_if.sv
// rtl/std_seq_ctrl_if.sv - command, config and sequence-output bundle for std_seq_ctrl
// The master side issues commands and consumes the sequence; the slave side is the controller.
interface std_seq_ctrl_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic [DIV_W-1:0] cfg_div;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             hold;
  logic             abort;
  logic [2:0]       seq_out;
  logic [2:0]       seq_idx;
  logic             busy;
  logic             step_pulse;
  logic             wrap_pulse;
  logic             done;

  modport master (
    output cfg_div, cmd_valid, cmd_op, cmd_cnt, hold, abort,
    input  cmd_ready, seq_out, seq_idx, busy, step_pulse, wrap_pulse, done
  );

  modport slave (
    input  cfg_div, cmd_valid, cmd_op, cmd_cnt, hold, abort,
    output cmd_ready, seq_out, seq_idx, busy, step_pulse, wrap_pulse, done
  );
endinterface

// File: rtl/std_seq_ctrl.sv
// rtl/std_seq_ctrl.sv - command-driven sequencer stepping the 8-code cycle 0,4,1,3,6,2,7,5
// A prescaler paces steps; RUN_CNT/STEP count steps down, RUN_CONT runs until abort.
module std_seq_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  std_seq_ctrl_if.slave bus
);

  localparam logic [1:0] OP_CLEAR    = 2'b00;
  localparam logic [1:0] OP_RUN_CONT = 2'b01;
  localparam logic [1:0] OP_RUN_CNT  = 2'b10;
  localparam logic [1:0] OP_STEP     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN_CONT = 2'd1,
    S_RUN_CNT  = 2'd2,
    S_CLR_ACK  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  function automatic logic [2:0] seq_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'd0;
      3'd1:    code = 3'd4;
      3'd2:    code = 3'd1;
      3'd3:    code = 3'd3;
      3'd4:    code = 3'd6;
      3'd5:    code = 3'd2;
      3'd6:    code = 3'd7;
      default: code = 3'd5;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    div_d   = div_q;
    rem_d   = rem_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          div_d   = bus.cfg_div;
          presc_d = '0;
          case (bus.cmd_op)
            OP_CLEAR: begin
              idx_d   = '0;
              state_d = S_CLR_ACK;
              done_d  = 1'b1;
            end
            OP_RUN_CONT: state_d = S_RUN_CONT;
            OP_RUN_CNT: begin
              // A zero count completes immediately without touching the index.
              if (bus.cmd_cnt == '0) begin
                state_d = S_CLR_ACK;
                done_d  = 1'b1;
              end else begin
                rem_d   = bus.cmd_cnt;
                state_d = S_RUN_CNT;
              end
            end
            OP_STEP: begin
              rem_d   = CNT_W'(1);
              state_d = S_RUN_CNT;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_RUN_CONT, S_RUN_CNT: begin
        // Abort takes priority over a step that would otherwise land on this edge.
        if (bus.abort) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (!bus.hold) begin
          if (presc_q == div_q) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
            step_d  = 1'b1;
            wrap_d  = (idx_q == 3'd7);
            if (state_q == S_RUN_CNT) begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end

      S_CLR_ACK: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q == S_RUN_CONT) || (state_q == S_RUN_CNT);
  assign bus.seq_idx    = idx_q;
  assign bus.seq_out    = seq_code(idx_q);
  assign bus.step_pulse = step_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_std_seq_ctrl.sv
// tb/tb_std_seq_ctrl.sv - directed self-checking bench for std_seq_ctrl
// Each task drives one scenario and checks outputs 1 time unit after the rising edge.
module tb_std_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  std_seq_ctrl_if #(.DIV_W(8), .CNT_W(8)) bus_if ();

  std_seq_ctrl #(.DIV_W(8), .CNT_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] div, input logic [7:0] cnt);
    bus_if.cmd_op    = op;
    bus_if.cfg_div   = div;
    bus_if.cmd_cnt   = cnt;
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    bus_if.cfg_div   = 8'hFF;
    bus_if.cmd_cnt   = 8'hFF;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 2'b01;
    bus_if.cfg_div   = 8'd0;
    bus_if.cmd_cnt   = 8'd0;
    bus_if.hold      = 1'b0;
    bus_if.abort     = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_if.seq_out !== 3'd0 || bus_if.seq_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_seq got out=%0d idx=%0d exp 0/0", bus_if.seq_out, bus_if.seq_idx);
    end
    checks++;
    if ({bus_if.busy, bus_if.step_pulse, bus_if.wrap_pulse, bus_if.done, bus_if.cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags got busy/step/wrap/done/ready=%b exp 00001",
               {bus_if.busy, bus_if.step_pulse, bus_if.wrap_pulse, bus_if.done, bus_if.cmd_ready});
    end
    bus_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear_run8();
    logic [2:0] exp_code [8];
    exp_code = '{3'd4, 3'd1, 3'd3, 3'd6, 3'd2, 3'd7, 3'd5, 3'd0};
    issue(2'b00, 8'd0, 8'd0);
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.seq_out !== 3'd0 || bus_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ack got done=%b out=%0d ready=%b exp 1/0/0", bus_if.done, bus_if.seq_out, bus_if.cmd_ready);
    end
    tick();
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_idle got done=%b ready=%b exp 0/1", bus_if.done, bus_if.cmd_ready);
    end
    issue(2'b10, 8'd0, 8'd8);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL run8_start got busy=%b step=%b exp 1/0", bus_if.busy, bus_if.step_pulse);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus_if.step_pulse !== 1'b1 || bus_if.seq_out !== exp_code[i] ||
          bus_if.wrap_pulse !== (i == 7) || bus_if.done !== (i == 7)) begin
        errors++;
        $display("FAIL run8_step%0d got step=%b out=%0d wrap=%b done=%b exp 1/%0d/%b/%b",
                 i, bus_if.step_pulse, bus_if.seq_out, bus_if.wrap_pulse, bus_if.done,
                 exp_code[i], (i == 7), (i == 7));
      end
    end
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run8_end got busy=%b ready=%b exp 0/1", bus_if.busy, bus_if.cmd_ready);
    end
    tick();
    checks++;
    if (bus_if.step_pulse !== 1'b0 || bus_if.done !== 1'b0 || bus_if.seq_idx !== 3'd0) begin
      errors++;
      $display("FAIL run8_after got step=%b done=%b idx=%0d exp 0/0/0", bus_if.step_pulse, bus_if.done, bus_if.seq_idx);
    end
  endtask

  task automatic test_run_cont_hold();
    issue(2'b01, 8'd3, 8'd0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (bus_if.step_pulse !== (c == 4 || c == 8)) begin
        errors++;
        $display("FAIL cont_period c=%0d got step=%b exp %b", c, bus_if.step_pulse, (c == 4 || c == 8));
      end
    end
    checks++;
    if (bus_if.seq_out !== 3'd1 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL cont_two_steps got out=%0d busy=%b exp 1/1", bus_if.seq_out, bus_if.busy);
    end
    // Hold covers 5 edges starting one edge into the period: step moves from offset 4 to 9.
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) bus_if.hold = 1'b1;
      if (c == 7) bus_if.hold = 1'b0;
      tick();
      checks++;
      if (bus_if.step_pulse !== (c == 9)) begin
        errors++;
        $display("FAIL cont_hold c=%0d got step=%b exp %b", c, bus_if.step_pulse, (c == 9));
      end
    end
    checks++;
    if (bus_if.seq_out !== 3'd3 || bus_if.seq_idx !== 3'd3) begin
      errors++;
      $display("FAIL cont_hold_code got out=%0d idx=%0d exp 3/3", bus_if.seq_out, bus_if.seq_idx);
    end
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.cmd_ready !== 1'b1 || bus_if.done !== 1'b0 || bus_if.seq_idx !== 3'd3) begin
      errors++;
      $display("FAIL cont_abort got busy=%b ready=%b done=%b idx=%0d exp 0/1/0/3",
               bus_if.busy, bus_if.cmd_ready, bus_if.done, bus_if.seq_idx);
    end
  endtask

  task automatic test_step();
    issue(2'b00, 8'd0, 8'd0);
    tick();
    issue(2'b10, 8'd0, 8'd2);
    tick();
    tick();
    tick();
    checks++;
    if (bus_if.seq_idx !== 3'd2 || bus_if.seq_out !== 3'd1 || bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL step_setup got idx=%0d out=%0d ready=%b exp 2/1/1", bus_if.seq_idx, bus_if.seq_out, bus_if.cmd_ready);
    end
    issue(2'b11, 8'd1, 8'd200);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL step_accept got busy=%b step=%b exp 1/0", bus_if.busy, bus_if.step_pulse);
    end
    tick();
    checks++;
    if (bus_if.step_pulse !== 1'b0 || bus_if.seq_out !== 3'd1) begin
      errors++;
      $display("FAIL step_wait got step=%b out=%0d exp 0/1", bus_if.step_pulse, bus_if.seq_out);
    end
    tick();
    checks++;
    if (bus_if.step_pulse !== 1'b1 || bus_if.done !== 1'b1 || bus_if.seq_out !== 3'd3 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL step_fire got step=%b done=%b out=%0d busy=%b exp 1/1/3/0",
               bus_if.step_pulse, bus_if.done, bus_if.seq_out, bus_if.busy);
    end
    tick();
    checks++;
    if (bus_if.step_pulse !== 1'b0 || bus_if.done !== 1'b0 || bus_if.cmd_ready !== 1'b1 || bus_if.seq_idx !== 3'd3) begin
      errors++;
      $display("FAIL step_after got step=%b done=%b ready=%b idx=%0d exp 0/0/1/3",
               bus_if.step_pulse, bus_if.done, bus_if.cmd_ready, bus_if.seq_idx);
    end
  endtask

  task automatic test_run_cnt_zero();
    issue(2'b10, 8'd0, 8'd0);
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.step_pulse !== 1'b0 || bus_if.seq_idx !== 3'd3 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL cnt0_ack got done=%b step=%b idx=%0d busy=%b exp 1/0/3/0",
               bus_if.done, bus_if.step_pulse, bus_if.seq_idx, bus_if.busy);
    end
    tick();
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.step_pulse !== 1'b0 || bus_if.cmd_ready !== 1'b1 || bus_if.seq_idx !== 3'd3) begin
      errors++;
      $display("FAIL cnt0_idle got done=%b step=%b ready=%b idx=%0d exp 0/0/1/3",
               bus_if.done, bus_if.step_pulse, bus_if.cmd_ready, bus_if.seq_idx);
    end
  endtask

  task automatic test_abort_pending_cmd();
    issue(2'b01, 8'd0, 8'd0);
    // Keep a STEP request pending for the whole run; it must wait for cmd_ready.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 2'b11;
    bus_if.cfg_div   = 8'd0;
    tick();
    checks++;
    if (bus_if.seq_idx !== 3'd4 || bus_if.step_pulse !== 1'b1 || bus_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_run1 got idx=%0d step=%b ready=%b exp 4/1/0", bus_if.seq_idx, bus_if.step_pulse, bus_if.cmd_ready);
    end
    tick();
    checks++;
    if (bus_if.seq_idx !== 3'd5 || bus_if.seq_out !== 3'd2 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_run2 got idx=%0d out=%0d busy=%b exp 5/2/1", bus_if.seq_idx, bus_if.seq_out, bus_if.busy);
    end
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    checks++;
    if (bus_if.step_pulse !== 1'b0 || bus_if.seq_idx !== 3'd5 || bus_if.busy !== 1'b0 ||
        bus_if.done !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_edge got step=%b idx=%0d busy=%b done=%b ready=%b exp 0/5/0/0/1",
               bus_if.step_pulse, bus_if.seq_idx, bus_if.busy, bus_if.done, bus_if.cmd_ready);
    end
    tick();
    bus_if.cmd_valid = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending_accept got busy=%b ready=%b exp 1/0", bus_if.busy, bus_if.cmd_ready);
    end
    tick();
    checks++;
    if (bus_if.step_pulse !== 1'b1 || bus_if.done !== 1'b1 || bus_if.seq_out !== 3'd7 || bus_if.seq_idx !== 3'd6) begin
      errors++;
      $display("FAIL pending_step got step=%b done=%b out=%0d idx=%0d exp 1/1/7/6",
               bus_if.step_pulse, bus_if.done, bus_if.seq_out, bus_if.seq_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    issue(2'b10, 8'd0, 8'd10);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus_if.seq_idx !== 3'd5 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got idx=%0d busy=%b exp 5/1", bus_if.seq_idx, bus_if.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.seq_out !== 3'd0 || bus_if.seq_idx !== 3'd0 || bus_if.busy !== 1'b0 ||
        bus_if.step_pulse !== 1'b0 || bus_if.done !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async got out=%0d idx=%0d busy=%b step=%b done=%b ready=%b exp 0/0/0/0/0/1",
               bus_if.seq_out, bus_if.seq_idx, bus_if.busy, bus_if.step_pulse, bus_if.done, bus_if.cmd_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus_if.step_pulse !== 1'b0 || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 ||
          bus_if.seq_idx !== 3'd0 || bus_if.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL midrst_after%0d got step=%b done=%b busy=%b idx=%0d ready=%b exp 0/0/0/0/1",
                 i, bus_if.step_pulse, bus_if.done, bus_if.busy, bus_if.seq_idx, bus_if.cmd_ready);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clear_run8();
    test_run_cont_hold();
    test_step();
    test_run_cnt_zero();
    test_abort_pending_cmd();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
